// File: rtl/obstacle_scheduler.sv
// Frame-rate scheduler for scrolling cactus obstacles: advances slots once
// per frame, spawns at pseudo-random gaps, retires off-screen ones, ramps speed.
module obstacle_scheduler #(
    parameter int NUM_SLOTS   = 3,
    parameter int SCREEN_W    = 640,
    parameter int SPRITE_W    = 60,
    parameter int MIN_GAP     = 200,
    parameter int SPEED_INIT  = 4,
    parameter int SPEED_MAX   = 12,
    parameter int RAMP_FRAMES = 600
) (
    input  logic                   clkdiv,
    input  logic                   RESET,
    input  logic                   fresh,
    input  logic                   game_status,
    input  logic                   restart,
    input  logic                   collision,
    output logic [NUM_SLOTS-1:0]   obj_active,
    output logic [10*NUM_SLOTS-1:0] obj_pos,
    output logic [3:0]             speed,
    output logic [15:0]            score,
    output logic                   halted,
    output logic                   frame_done
);

    localparam int RETIRE = SCREEN_W + SPRITE_W;
    localparam int IW     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int GW     = $clog2(MIN_GAP + 256);
    localparam int RW     = $clog2(RAMP_FRAMES + 1);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        UPDATE,
        SPAWN,
        HALT
    } state_t;

    state_t                       state_q, state_d;
    logic                         fresh_q, fresh_d;
    logic                         pending_q, pending_d;
    logic [15:0]                  lfsr_q, lfsr_d;
    logic [IW-1:0]                idx_q, idx_d;
    logic [GW-1:0]                gap_q, gap_d;
    logic [RW-1:0]                ramp_q, ramp_d;
    logic [3:0]                   speed_q, speed_d;
    logic [15:0]                  score_q, score_d;
    logic [NUM_SLOTS-1:0]         active_q, active_d;
    logic [NUM_SLOTS-1:0][9:0]    pos_q, pos_d;
    logic                         frame_done_q, frame_done_d;

    logic                         tick;
    logic                         lfsr_fb;
    logic                         taken;
    logic [NUM_SLOTS-1:0]         spawn_oh;
    logic [10:0]                  sum;

    always_ff @(posedge clkdiv or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            fresh_q      <= 1'b0;
            pending_q    <= 1'b0;
            lfsr_q       <= 16'hACE1;
            idx_q        <= '0;
            gap_q        <= GW'(MIN_GAP);
            ramp_q       <= '0;
            speed_q      <= 4'(SPEED_INIT);
            score_q      <= '0;
            active_q     <= '0;
            pos_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fresh_q      <= fresh_d;
            pending_q    <= pending_d;
            lfsr_q       <= lfsr_d;
            idx_q        <= idx_d;
            gap_q        <= gap_d;
            ramp_q       <= ramp_d;
            speed_q      <= speed_d;
            score_q      <= score_d;
            active_q     <= active_d;
            pos_q        <= pos_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Lowest free slot, one-hot
    always_comb begin
        taken    = 1'b0;
        spawn_oh = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!active_q[i] && !taken) begin
                spawn_oh[i] = 1'b1;
                taken       = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        idx_d        = idx_q;
        gap_d        = gap_q;
        ramp_d       = ramp_q;
        speed_d      = speed_q;
        score_d      = score_q;
        active_d     = active_q;
        pos_d        = pos_q;
        frame_done_d = 1'b0;
        sum          = '0;

        fresh_d = fresh;
        tick    = fresh_q & ~fresh;
        lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
        lfsr_d  = {lfsr_fb, lfsr_q[15:1]};

        if (tick && !pending_q) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                pending_d = 1'b0;
                if (game_status) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (collision) begin
                    state_d = HALT;
                end else if (!game_status) begin
                    state_d = IDLE;
                end else if (pending_q) begin
                    state_d   = UPDATE;
                    idx_d     = '0;
                    pending_d = 1'b0;
                end
            end
            UPDATE: begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (idx_q == IW'(i) && active_q[i]) begin
                        sum = {1'b0, pos_q[i]} + 11'(speed_q);
                        if (sum >= 11'(RETIRE)) begin
                            active_d[i] = 1'b0;
                            pos_d[i]    = '0;
                            if (score_q != 16'hFFFF) begin
                                score_d = score_q + 16'd1;
                            end
                        end else begin
                            pos_d[i] = sum[9:0];
                        end
                    end
                end
                if (idx_q == IW'(NUM_SLOTS - 1)) begin
                    state_d = SPAWN;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            SPAWN: begin
                if (gap_q == '0 && taken) begin
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if (spawn_oh[i]) begin
                            active_d[i] = 1'b1;
                            pos_d[i]    = '0;
                        end
                    end
                    gap_d = GW'(MIN_GAP) + GW'(lfsr_q[7:0]);
                end else if (gap_q > GW'(speed_q)) begin
                    gap_d = gap_q - GW'(speed_q);
                end else begin
                    gap_d = '0;
                end
                if (ramp_q == RW'(RAMP_FRAMES - 1)) begin
                    ramp_d = '0;
                    if (speed_q < 4'(SPEED_MAX)) begin
                        speed_d = speed_q + 4'd1;
                    end
                end else begin
                    ramp_d = ramp_q + RW'(1);
                end
                state_d      = RUN;
                frame_done_d = 1'b1;
            end
            HALT: begin
                pending_d = pending_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Restart wins over every state, including HALT
        if (restart) begin
            state_d      = IDLE;
            pending_d    = 1'b0;
            idx_d        = '0;
            gap_d        = GW'(MIN_GAP);
            ramp_d       = '0;
            speed_d      = 4'(SPEED_INIT);
            score_d      = '0;
            active_d     = '0;
            pos_d        = '0;
            frame_done_d = 1'b0;
        end
    end

    assign obj_active = active_q;
    assign obj_pos    = pos_q;
    assign speed      = speed_q;
    assign score      = score_q;
    assign halted     = (state_q == HALT);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler: spawn, retire, halt, pause,
// tick storm and speed ramp with hand-computed expectations.
module tb_obstacle_scheduler;

    logic        clkdiv = 1'b0;
    logic        RESET = 1'b1;
    logic        fresh = 1'b0;
    logic        game_status = 1'b0;
    logic        restart = 1'b0;
    logic        collision = 1'b0;
    logic [2:0]  obj_active;
    logic [29:0] obj_pos;
    logic [3:0]  speed;
    logic [15:0] score;
    logic        halted;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    obstacle_scheduler dut (
        .clkdiv      (clkdiv),
        .RESET       (RESET),
        .fresh       (fresh),
        .game_status (game_status),
        .restart     (restart),
        .collision   (collision),
        .obj_active  (obj_active),
        .obj_pos     (obj_pos),
        .speed       (speed),
        .score       (score),
        .halted      (halted),
        .frame_done  (frame_done)
    );

    always #5 clkdiv = ~clkdiv;

    task automatic cyc();
        @(posedge clkdiv);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One fresh fall; reports frame_done pulses and the edge (after k) seen
    task automatic frame(output int cnt, output int at);
        cnt = 0;
        at  = -1;
        fresh = 1'b1;
        cyc();
        fresh = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cyc();
            if (frame_done) begin
                cnt++;
                at = i;
            end
        end
    endtask

    task automatic frames(input int n, output int fds);
        int c;
        int a;
        fds = 0;
        repeat (n) begin
            frame(c, a);
            fds += c;
        end
    endtask

    initial begin
        int fc;
        int fa;
        int fds;
        int good;

        repeat (3) cyc();
        chk("rst_active", obj_active, 0);
        chk("rst_pos", obj_pos, 0);
        chk("rst_speed", speed, 4);
        chk("rst_score", score, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fd", frame_done, 0);

        // First spawn and retirement
        RESET = 1'b0;
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        game_status = 1'b1;
        cyc();
        frame(fc, fa);
        chk("fd_cnt_f1", fc, 1);
        chk("fd_at_f1", fa, 5);
        good = (fc == 1 && fa == 5) ? 1 : 0;
        for (int f = 2; f <= 50; f++) begin
            frame(fc, fa);
            if (fc == 1 && fa == 5) good++;
        end
        chk("fd_every_frame", good, 50);
        chk("no_spawn_f50", obj_active, 0);
        frame(fc, fa);
        chk("spawn_act_f51", obj_active, 3'b001);
        chk("spawn_pos_f51", obj_pos[9:0], 0);
        frame(fc, fa);
        chk("pos_f52", obj_pos[9:0], 4);
        frames(173, fds);
        chk("pos_f225", obj_pos[9:0], 696);
        chk("act_f225", obj_active[0], 1);
        chk("score_f225", score, 0);
        frame(fc, fa);
        chk("retire_pos", obj_pos[9:0], 0);
        chk("retire_score", score, 1);
        for (int f = 0; f < 120 && !obj_active[0]; f++) begin
            frame(fc, fa);
        end
        chk("reuse_slot0", obj_active[0], 1);
        chk("reuse_pos0", obj_pos[9:0], 0);

        // RESET in the middle of an UPDATE
        fresh = 1'b1;
        cyc();
        fresh = 1'b0;
        cyc();
        cyc();
        cyc();
        #2 RESET = 1'b1;
        #1;
        chk("midrst_active", obj_active, 0);
        chk("midrst_pos", obj_pos, 0);
        chk("midrst_speed", speed, 4);
        chk("midrst_score", score, 0);
        chk("midrst_fd", frame_done, 0);
        game_status = 1'b0;
        cyc();
        RESET = 1'b0;
        cyc();
        frame(fc, fa);
        chk("idle_no_frame", fc, 0);

        // Pause, tick storm, collision
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        game_status = 1'b1;
        cyc();
        frames(52, fds);
        chk("b_pos_f52", obj_pos, 30'd4);
        chk("b_act_f52", obj_active, 3'b001);
        game_status = 1'b0;
        cyc();
        frames(5, fds);
        chk("pause_pos", obj_pos, 30'd4);
        chk("pause_fd", fds, 0);
        game_status = 1'b1;
        cyc();
        frames(1, fds);
        chk("resume_pos", obj_pos, 30'd8);

        fresh = 1'b1;
        cyc();
        fresh = 1'b0;
        cyc();
        fresh = 1'b1;
        cyc();
        fresh = 1'b0;
        cyc();
        fresh = 1'b1;
        cyc();
        fresh = 1'b0;
        fc = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (frame_done) fc++;
        end
        chk("storm_fd", fc, 2);
        chk("storm_pos", obj_pos, 30'd16);

        collision = 1'b1;
        cyc();
        chk("halt_on", halted, 1);
        frames(5, fds);
        fc = fds;
        collision = 1'b0;
        game_status = 1'b0;
        frames(5, fds);
        fc += fds;
        chk("halt_fd", fc, 0);
        chk("halt_pos", obj_pos, 30'd16);
        chk("halt_act", obj_active, 3'b001);
        chk("halt_score", score, 0);
        chk("halt_hold", halted, 1);
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        chk("rs_halted", halted, 0);
        chk("rs_active", obj_active, 0);
        chk("rs_pos", obj_pos, 0);
        chk("rs_speed", speed, 4);
        chk("rs_score", score, 0);

        // Speed ramp
        game_status = 1'b1;
        cyc();
        frames(599, fds);
        chk("speed_599", speed, 4);
        frames(1, fds);
        chk("speed_600", speed, 5);
        frames(4199, fds);
        chk("speed_4799", speed, 11);
        frames(1, fds);
        chk("speed_4800", speed, 12);
        frames(600, fds);
        chk("speed_cap", speed, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/obstacle_scheduler.md
# obstacle_scheduler

Frame-rate scheduler for the scrolling cactus obstacles. Owns up to NUM_SLOTS obstacle instances and advances each active obstacle's scroll position once per video frame. Spawns new obstacles at pseudo-random gaps, retires obstacles that leave the screen, ramps scroll speed and counts score. Sits between the VGA frame strobe and the per-slot obstacle renderers, which draw at x = SCREEN_W − position.

## Interface
- NUM_SLOTS, 3, number of obstacle instances.
- SCREEN_W, 640, visible width in px.
- SPRITE_W, 60, obstacle width in px; retirement threshold is SCREEN_W+SPRITE_W.
- MIN_GAP, 200, minimum spawn gap in px.
- SPEED_INIT, 4, px/frame after reset or restart.
- SPEED_MAX, 12, speed ceiling.
- RAMP_FRAMES, 600, frames per speed increment.
- clkdiv  in  1  system clock; all logic on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- fresh  in  1  frame strobe from VGA; a falling edge marks a frame boundary.
- game_status  in  1  run enable; 0 pauses.
- restart  in  1  single-cycle synchronous clear of game state.
- collision  in  1  hit flag from the collision detector.
- obj_active  out  NUM_SLOTS  slot i holds a live obstacle.
- obj_pos  out  10*NUM_SLOTS  slot i position in bits [10i+9:10i], range 0..SCREEN_W+SPRITE_W−1.
- speed  out  4  current px/frame.
- score  out  16  obstacles retired; saturates at 16'hFFFF.
- halted  out  1  high in HALT.
- frame_done  out  1  one-cycle pulse when a frame update completes.

## Operation
- Reset values:
  - obj_active=0, obj_pos=0, speed=SPEED_INIT, score=0, halted=0, frame_done=0.
  - State IDLE; gap=MIN_GAP; ramp counter=0; fresh_q=0; LFSR=16'hACE1.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It steps every cycle in every state and is never reseeded by restart.
- Frame tick: fresh_q samples fresh every cycle; tick = fresh_q & ~fresh.
- The tick is latched into a single pending flag. Additional ticks while the flag is set are dropped.
- States:
  - IDLE:
    - game_status=1 → RUN.
    - Pending ticks are discarded.
  - RUN:
    - collision=1 → HALT (priority over tick).
    - game_status=0 → IDLE; state is retained (pause).
    - pending tick → UPDATE, slot index=0, pending cleared.
  - UPDATE: one slot per cycle.
    - If the slot is active: pos += speed, 11-bit sum.
    - If the sum ≥ SCREEN_W+SPRITE_W: active=0, pos=0, score+1 (saturating).
    - After slot NUM_SLOTS−1 → SPAWN.
  - SPAWN: one cycle.
    - If gap==0 and a free slot exists: the lowest free slot gets active=1, pos=0, and gap=MIN_GAP+LFSR[7:0].
    - Otherwise: gap = gap>speed ? gap−speed : 0. With gap==0 and no free slot, gap stays 0.
    - Ramp counter increments. When it reaches RAMP_FRAMES: counter=0, speed=min(speed+1, SPEED_MAX).
    - → RUN; frame_done=1 for the next cycle.
  - HALT:
    - All registers frozen, halted=1.
    - Ticks, game_status and collision are ignored.
    - Exit only via restart or RESET.
- Collision during UPDATE/SPAWN: the frame completes first; HALT is taken on return to RUN if collision is still high.
- restart (any state, highest synchronous priority): clears slots, score, ramp counter and pending flag; speed=SPEED_INIT; gap=MIN_GAP; halted=0 → IDLE.
- RESET mid-UPDATE: immediate return to reset values; the partial frame is lost.

## Timing
- Edge k samples fresh=0 with fresh_q=1 → pending set at edge k.
- In RUN, UPDATE is entered at edge k+1. Slot i is updated at edge k+2+i.
- SPAWN completes at edge k+2+NUM_SLOTS. frame_done is high during the following cycle.
- With NUM_SLOTS=3, all outputs are final 5 edges after the falling edge of fresh.
- Outputs are registered and stable between updates; renderers sample them freely.
- Minimum frame period: NUM_SLOTS+3 cycles. Faster strobes drop ticks as above.

## Test plan
- Reset and power-up: assert RESET mid-UPDATE → obj_active=0, obj_pos=0, speed=4, score=0, frame_done=0, state IDLE.
- First spawn: restart, then game_status=1 with 60 frame strobes.
  - Frames 1–50 decrement gap 200→0.
  - Frame 51 spawns slot 0 at pos 0; frame 52 gives pos 4.
  - frame_done pulses once per frame, 5 cycles after each fresh fall.
- Retirement: slot 0 at pos 696 with speed 4, one frame → obj_active[0]=0, obj_pos=0, score increments by 1. Slot 0 is reused by the next spawn.
- Collision and restart:
  - collision=1 in RUN → halted=1; positions and score unchanged across 10 frames.
  - restart → halted=0, slots clear, speed=4.
- Speed ramp: run 600 frames → speed=5. Run 8×600 frames → speed=12 and holds at 12 thereafter.
- Pause and tick storm:
  - game_status=0 → 5 frames cause no position change.
  - Two fresh falls inside one UPDATE → exactly one extra frame is processed.
